// File: rtl/mux_n_scan.sv
// Purpose: registered N:1 channel mux with manual index load or auto round-robin scan over valid channels.
// Latency: 1 cycle from din/din_valid (and from the select decision) to y/y_valid/y_ch.
// Backpressure: none; the downstream path samples y every cycle and there is no ready input.
//
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_din, i_din_valid  N packed channels of WIDTH bits plus per-channel valid
//   i_mode              0 = manual select, 1 = auto round-robin scan
//   i_sel, i_sel_load   manual channel index and its load strobe
//   o_y, o_y_valid      registered data/valid of the selected channel
//   o_y_ch              channel index that produced o_y
//   o_switch_p          pulse: the selected channel changed on the last edge
//   o_sel_err           pulse: manual load with an out-of-range index
module mux_n_scan #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N*WIDTH-1:0] i_din,
  input  logic [N-1:0]       i_din_valid,
  input  logic               i_mode,
  input  logic [SELW-1:0]    i_sel,
  input  logic               i_sel_load,
  output logic [WIDTH-1:0]   o_y,
  output logic               o_y_valid,
  output logic [SELW-1:0]    o_y_ch,
  output logic               o_switch_p,
  output logic               o_sel_err
);

  // Dwell counter needs at least one bit even when DWELL == 1.
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW:0]   N_EXT      = (SELW + 1)'(N);

  logic [SELW-1:0]  r_cur_ch;
  logic [CNTW-1:0]  r_dwell_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;
  logic             r_switch_p;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_ch_dat [N];
  logic [SELW:0]    w_sum;
  logic [SELW-1:0]  w_auto_ch;
  logic             w_found;
  logic [SELW-1:0]  w_next_ch;
  logic [CNTW-1:0]  w_next_cnt;
  logic             w_sel_err;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_ch_dat[k] = i_din[k*WIDTH +: WIDTH];
  end

  // Next valid channel after the current one, searched cyclically.
  // Falls back to the current channel when no other channel is valid,
  // regardless of whether the current channel itself is valid.
  always_comb begin
    w_sum     = '0;
    w_auto_ch = r_cur_ch;
    w_found   = 1'b0;
    for (int i = 1; i < N; i++) begin
      w_sum = {1'b0, r_cur_ch} + (SELW + 1)'(i);
      if (w_sum >= N_EXT) begin
        w_sum = w_sum - N_EXT;
      end
      if (!w_found && i_din_valid[w_sum[SELW-1:0]]) begin
        w_auto_ch = w_sum[SELW-1:0];
        w_found   = 1'b1;
      end
    end
  end

  // Channel decision. Manual mode keeps the dwell counter at zero so that
  // a later switch into auto mode always starts a fresh dwell period.
  always_comb begin
    w_next_ch  = r_cur_ch;
    w_next_cnt = '0;
    w_sel_err  = 1'b0;
    if (i_mode) begin
      if (r_dwell_cnt == DWELL_LAST) begin
        w_next_ch = w_auto_ch;
      end else begin
        w_next_cnt = r_dwell_cnt + CNTW'(1);
      end
    end else if (i_sel_load) begin
      if ({1'b0, i_sel} < N_EXT) begin
        w_next_ch = i_sel;
      end else begin
        w_sel_err = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_ch    <= '0;
      r_dwell_cnt <= '0;
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_switch_p  <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_cur_ch    <= w_next_ch;
      r_dwell_cnt <= w_next_cnt;
      r_y         <= w_ch_dat[w_next_ch];
      r_y_valid   <= i_din_valid[w_next_ch];
      r_switch_p  <= (w_next_ch != r_cur_ch);
      r_sel_err   <= w_sel_err;
    end
  end

  // The registered current channel is by construction the source of o_y.
  assign o_y        = r_y;
  assign o_y_valid  = r_y_valid;
  assign o_y_ch     = r_cur_ch;
  assign o_switch_p = r_switch_p;
  assign o_sel_err  = r_sel_err;

endmodule

// File: tb/tb_mux_n_scan.sv
module tb_mux_n_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, N=4, DWELL=4
  logic        rst;
  logic [31:0] din;
  logic [3:0]  din_valid;
  logic        mode;
  logic [1:0]  sel;
  logic        sel_load;
  logic [7:0]  y;
  logic        y_valid;
  logic [1:0]  y_ch;
  logic        switch_p;
  logic        sel_err;

  // Instance B: WIDTH=8, N=3, DWELL=1
  logic        rst3;
  logic [23:0] din3;
  logic [2:0]  valid3;
  logic        mode3;
  logic [1:0]  sel3;
  logic        sel_load3;
  logic [7:0]  y3;
  logic        y_valid3;
  logic [1:0]  y_ch3;
  logic        switch_p3;
  logic        sel_err3;

  int checks = 0;
  int failures = 0;

  mux_n_scan #(.WIDTH(8), .N(4), .DWELL(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid),
    .i_mode(mode), .i_sel(sel), .i_sel_load(sel_load),
    .o_y(y), .o_y_valid(y_valid), .o_y_ch(y_ch),
    .o_switch_p(switch_p), .o_sel_err(sel_err)
  );

  mux_n_scan #(.WIDTH(8), .N(3), .DWELL(1)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_din(din3), .i_din_valid(valid3),
    .i_mode(mode3), .i_sel(sel3), .i_sel_load(sel_load3),
    .o_y(y3), .o_y_valid(y_valid3), .o_y_ch(y_ch3),
    .o_switch_p(switch_p3), .o_sel_err(sel_err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] ey, input logic ev,
                         input logic [1:0] ec, input logic es, input logic ee);
    chk($sformatf("%s.y", tag), {24'h0, y}, {24'h0, ey});
    chk($sformatf("%s.y_valid", tag), {31'h0, y_valid}, {31'h0, ev});
    chk($sformatf("%s.y_ch", tag), {30'h0, y_ch}, {30'h0, ec});
    chk($sformatf("%s.switch_p", tag), {31'h0, switch_p}, {31'h0, es});
    chk($sformatf("%s.sel_err", tag), {31'h0, sel_err}, {31'h0, ee});
  endtask

  task automatic check_b(input string tag, input logic [7:0] ey, input logic ev,
                         input logic [1:0] ec, input logic es, input logic ee);
    chk($sformatf("%s.y", tag), {24'h0, y3}, {24'h0, ey});
    chk($sformatf("%s.y_valid", tag), {31'h0, y_valid3}, {31'h0, ev});
    chk($sformatf("%s.y_ch", tag), {30'h0, y_ch3}, {30'h0, ec});
    chk($sformatf("%s.switch_p", tag), {31'h0, switch_p3}, {31'h0, es});
    chk($sformatf("%s.sel_err", tag), {31'h0, sel_err3}, {31'h0, ee});
  endtask

  initial begin
    // Channel data of instance A after ch2 is rewritten to 0x5A.
    logic [7:0] dat [4];
    logic [1:0] scan_ch [16];
    logic [1:0] skip_ch [15];
    logic [1:0] prev;
    logic [3:0] vmask;
    dat     = '{8'h11, 8'h22, 8'h5A, 8'h44};
    scan_ch = '{0,0,0,1, 1,1,1,2, 2,2,2,3, 3,3,3,0};
    skip_ch = '{0,0,0,1, 1,1,1,3, 3,3,3,1, 1,1,1};

    rst = 1'b1; din = 32'h44332211; din_valid = 4'hF; mode = 1'b0; sel = 2'd0; sel_load = 1'b0;
    rst3 = 1'b1; din3 = 24'hCCBBAA; valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd0; sel_load3 = 1'b0;

    // Reset held for two cycles.
    step(); check_a("rst1", 8'h00, 0, 0, 0, 0);
    step(); check_a("rst2", 8'h00, 0, 0, 0, 0);
    rst = 1'b0;
    step(); check_a("release", 8'h11, 1, 0, 0, 0);

    // Manual load of channel 2, then a data change on that channel.
    sel = 2'd2; sel_load = 1'b1;
    step(); check_a("load2", 8'h33, 1, 2, 1, 0);
    sel_load = 1'b0;
    step(); check_a("load2_hold", 8'h33, 1, 2, 0, 0);
    din = 32'h445A2211;
    step(); check_a("din_change", 8'h5A, 1, 2, 0, 0);

    // Back to channel 0, then auto scan with all valid; sel_load must be ignored.
    sel = 2'd0; sel_load = 1'b1;
    step(); check_a("load0", 8'h11, 1, 0, 1, 0);
    mode = 1'b1; sel = 2'd3; sel_load = 1'b1;
    prev = 2'd0;
    for (int k = 0; k < 16; k++) begin
      step();
      check_a($sformatf("scan%0d", k), dat[scan_ch[k]], 1, scan_ch[k], scan_ch[k] != prev, 0);
      prev = scan_ch[k];
    end
    sel_load = 1'b0;

    // Skip invalid channels: 1010 -> scan 1,3,1.
    din_valid = 4'b1010; vmask = 4'b1010;
    for (int k = 0; k < 15; k++) begin
      step();
      check_a($sformatf("skip%0d", k), dat[skip_ch[k]], vmask[skip_ch[k]], skip_ch[k],
              skip_ch[k] != prev, 0);
      prev = skip_ch[k];
    end

    // Only the current channel valid: stay on ch1 across dwell boundaries.
    din_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      step(); check_a($sformatf("only1_%0d", k), 8'h22, 1, 1, 0, 0);
    end
    // Nothing valid: hold ch1 with y_valid low.
    din_valid = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step(); check_a($sformatf("none%0d", k), 8'h22, 0, 1, 0, 0);
    end

    // All valid again: move to ch2, then drop to manual on its 2nd dwell cycle.
    din_valid = 4'hF;
    step(); check_a("to_ch2", 8'h5A, 1, 2, 1, 0);
    step(); check_a("ch2_dwell1", 8'h5A, 1, 2, 0, 0);
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); check_a($sformatf("manual_hold%0d", k), 8'h5A, 1, 2, 0, 0);
    end
    // Re-enter auto: a full fresh dwell of 4 before moving to ch3.
    mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); check_a($sformatf("reauto%0d", k), 8'h5A, 1, 2, 0, 0);
    end
    step(); check_a("reauto_move", 8'h44, 1, 3, 1, 0);

    // Reset mid-dwell, then the dwell restarts from zero on ch0.
    step(); check_a("pre_rst0", 8'h44, 1, 3, 0, 0);
    step(); check_a("pre_rst1", 8'h44, 1, 3, 0, 0);
    rst = 1'b1;
    step(); check_a("mid_rst", 8'h00, 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); check_a($sformatf("post_rst%0d", k), 8'h11, 1, 0, 0, 0);
    end
    step(); check_a("post_rst_move", 8'h22, 1, 1, 1, 0);

    // sel_load on the same edge as the 1->0 mode change is honoured.
    mode = 1'b0; sel = 2'd3; sel_load = 1'b1;
    step(); check_a("mode_off_load", 8'h44, 1, 3, 1, 0);
    sel_load = 1'b0;

    // Instance B: N=3 out-of-range select, then DWELL=1 scan with wrap.
    step(); check_b("b_rst", 8'h00, 0, 0, 0, 0);
    rst3 = 1'b0;
    step(); check_b("b_release", 8'hAA, 1, 0, 0, 0);
    sel3 = 2'd3; sel_load3 = 1'b1;
    step(); check_b("b_bad_sel", 8'hAA, 1, 0, 0, 1);
    sel_load3 = 1'b0;
    step(); check_b("b_err_clear", 8'hAA, 1, 0, 0, 0);
    sel3 = 2'd2; sel_load3 = 1'b1;
    step(); check_b("b_load2", 8'hCC, 1, 2, 1, 0);
    mode3 = 1'b1; sel3 = 2'd3; sel_load3 = 1'b1;
    step(); check_b("b_auto0", 8'hAA, 1, 0, 1, 0);
    step(); check_b("b_auto1", 8'hBB, 1, 1, 1, 0);
    step(); check_b("b_auto2", 8'hCC, 1, 2, 1, 0);
    step(); check_b("b_auto3", 8'hAA, 1, 0, 1, 0);
    valid3 = 3'b100;
    step(); check_b("b_only2", 8'hCC, 1, 2, 1, 0);
    step(); check_b("b_only2_hold", 8'hCC, 1, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_scan.md
Name: mux_n_scan

Overview:
- Parametrised, registered N:1 multiplexer; successor to the team's combinational 2:1 mux.
- Selects one of N channels of WIDTH bits, in one of two modes:
  - manual: host loads a channel index;
  - auto-scan: round-robin over valid channels, holding each for a programmable dwell time.
- Sits between multi-source data producers and a single downstream consumer (e.g. a shared display/monitor path).

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- N, 4, number of input channels (>=2).
- DWELL, 4, cycles each channel is held in auto mode (>=1).
- SELW, $clog2(N), channel index width. Derived; never overridden.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  N*WIDTH  packed channel data; channel k = din[k*WIDTH +: WIDTH].
- din_valid  in  N  per-channel valid; bit k qualifies channel k.
- mode  in  1  0 = manual select, 1 = auto round-robin scan.
- sel  in  SELW  channel index for manual load.
- sel_load  in  1  load sel into current channel (manual mode only).
- y  out  WIDTH  registered selected data.
- y_valid  out  1  registered din_valid of the selected channel.
- y_ch  out  SELW  channel index that produced the current y.
- switch_p  out  1  one-cycle pulse: the channel changed on this edge.
- sel_err  out  1  one-cycle pulse: sel_load with sel >= N in manual mode.

Behaviour:
- Reset (rst=1 at an edge) overrides everything:
  - y=0, y_valid=0, y_ch=0, switch_p=0, sel_err=0;
  - internal cur_ch=0, dwell_cnt=0.
  - Reset mid-scan abandons the dwell; the scan restarts at channel 0.
- Each edge:
  - next_ch is computed combinationally.
  - cur_ch<=next_ch; y<=din[next_ch]; y_valid<=din_valid[next_ch]; y_ch<=next_ch.
  - Latency: data/valid to y/y_valid is 1 cycle; a channel change is visible on y 1 cycle after the deciding edge inputs.
- Manual mode (mode=0):
  - sel_load=1 and sel<N: next_ch=sel.
  - sel_load=1 and sel>=N: next_ch=cur_ch and sel_err=1 for one cycle.
  - Otherwise next_ch=cur_ch.
  - dwell_cnt is held at 0.
- Auto mode (mode=1):
  - sel_load and sel are ignored; sel_err is never asserted.
  - dwell_cnt increments each cycle.
  - When dwell_cnt==DWELL-1, dwell_cnt<=0 and next_ch = first channel with din_valid=1, searching cyclically cur_ch+1, cur_ch+2, ... (index wraps N-1 -> 0).
  - If no other channel is valid, next_ch=cur_ch. This holds whether or not cur_ch itself is valid.
  - Otherwise next_ch=cur_ch.
- Mode changes:
  - 0->1: dwell_cnt starts from 0 on the first auto cycle; cur_ch is kept.
  - 1->0: cur_ch is kept; dwell_cnt forced to 0.
  - sel_load on the same edge as the 1->0 change is honoured, because mode is sampled as 0.
- switch_p=1 on the cycle after any edge where next_ch != cur_ch. Reset does not pulse it.
- DWELL=1: auto mode evaluates a move every cycle.

Test Plan:
- Reset/default: assert rst 2 cycles with din=0x44_33_22_11 and all valid -> y=0x00, y_ch=0, y_valid=0 during reset. First cycle after release -> y=0x11, y_ch=0.
- Manual load: mode=0, pulse sel_load with sel=2 -> next cycle y=0x33, y_ch=2, switch_p=1 for exactly 1 cycle. Then change din ch2 to 0x5A -> y=0x5A one cycle later.
- Invalid select: N=3, sel=3, sel_load=1 -> sel_err=1 for 1 cycle; y_ch unchanged; switch_p stays 0.
- Auto scan: mode=1, din_valid=4'b1111, start ch0 -> y_ch sequence 0,0,0,0,1,1,1,1,2,...,3,0. Each channel held exactly DWELL=4 cycles; switch_p pulses at each change.
- Skip invalid: auto mode, din_valid=4'b1010 from ch1 -> scan 1,3,1,3 at 4-cycle dwell. With din_valid=4'b0010 -> stays on ch1, no switch_p. With din_valid=0 -> y_ch held, y_valid=0.
- Mid-operation events:
  - sel_load=1 with sel=3 during auto -> ignored.
  - Switch mode to 0 on the 2nd dwell cycle on ch2 -> y_ch stays 2.
  - rst asserted mid-dwell -> y_ch=0 next cycle; dwell count restarts at 0 after release.
